// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
package mul_arb_pkg;

    localparam int OPW  = 32;
    localparam int RESW = 64;
    localparam int CNTW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Port index to a two-bit one-hot vector.
    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side and multiplier-side signals of the arbiter.
// slave: the arbiter itself; master: requesters plus multiplier.
interface mul_arbiter_if;
    import mul_arb_pkg::*;

    logic            req0;
    logic            req1;
    logic [OPW-1:0]  a0;
    logic [OPW-1:0]  b0;
    logic [OPW-1:0]  a1;
    logic [OPW-1:0]  b1;
    logic            ack0;
    logic            ack1;
    logic            done0;
    logic            done1;
    logic [RESW-1:0] res;
    logic            err;
    logic [OPW-1:0]  m_multiplier;
    logic [OPW-1:0]  m_multiplicand;
    logic            m_op_start;
    logic            m_op_clear;
    logic            m_op_done;
    logic [RESW-1:0] m_result;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, m_op_done, m_result,
        output ack0, ack1, done0, done1, res, err,
               m_multiplier, m_multiplicand, m_op_start, m_op_clear
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, m_op_done, m_result,
        input  ack0, ack1, done0, done1, res, err,
               m_multiplier, m_multiplicand, m_op_start, m_op_clear
    );

endinterface

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-port round-robin grant: a lone request wins, a tie goes to
// the port that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // Pick the winner from the current request pair and grant history.
    always_comb begin
        // NOTE: every output gets a default first, so no path through
        // the case leaves a signal unassigned and infers a latch.
        gnt    = 2'b00;
        gnt_id = 1'b0;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                gnt_id = 1'b0;
            end
            2'b10: begin
                gnt    = 2'b10;
                gnt_id = 1'b1;
            end
            2'b11: begin
                gnt_id = ~last_gnt;
                gnt    = last_gnt ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared 32x32
// multiplier: grants one requester, runs the start/clear handshake,
// returns the product and aborts a multiply that never finishes.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    mul_arbiter_if.slave  bus
);

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(TIMEOUT - 1);

    state_t          r_state;
    logic            r_last_gnt;
    logic            r_owner;
    logic [CNTW-1:0] r_cnt;
    logic [OPW-1:0]  r_mult;
    logic [OPW-1:0]  r_mcand;
    logic [RESW-1:0] r_res;
    logic [1:0]      r_ack;
    logic [1:0]      r_done;
    logic            r_err;
    logic            r_start;

    logic [1:0]      w_gnt;
    logic            w_gnt_id;
    logic            w_timeout;

    rr_arb2 u_rr_arb2 (
        .req      ({bus.req1, bus.req0}),
        .last_gnt (r_last_gnt),
        .gnt      (w_gnt),
        .gnt_id   (w_gnt_id)
    );

    assign w_timeout = (r_cnt == LAST_CNT);

    // Main sequencer: grant in IDLE, wait for the product in RUN, report in CLEAR.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every
        // register sees the pre-edge values of the others.
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
            r_owner    <= 1'b0;
            r_cnt      <= '0;
            r_mult     <= '0;
            r_mcand    <= '0;
            r_res      <= '0;
            r_ack      <= 2'b00;
            r_done     <= 2'b00;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-armed below.
            r_ack  <= 2'b00;
            r_done <= 2'b00;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_owner    <= w_gnt_id;
                        r_last_gnt <= w_gnt_id;
                        r_mult     <= w_gnt_id ? bus.a1 : bus.a0;
                        r_mcand    <= w_gnt_id ? bus.b1 : bus.b0;
                        r_ack      <= w_gnt;
                        r_start    <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNTW'(1);
                    // A product arriving on the last busy cycle beats the abort.
                    if (bus.m_op_done) begin
                        r_res   <= bus.m_result;
                        r_start <= 1'b0;
                        r_done  <= onehot2(r_owner);
                        r_state <= ST_CLEAR;
                    end else if (w_timeout) begin
                        r_res   <= '0;
                        r_err   <= 1'b1;
                        r_start <= 1'b0;
                        r_done  <= onehot2(r_owner);
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Clear is the only unregistered output so reset purges the multiplier at once.
    assign bus.m_op_clear     = reset | (r_state == ST_CLEAR);
    assign bus.m_op_start     = r_start;
    assign bus.m_multiplier   = r_mult;
    assign bus.m_multiplicand = r_mcand;
    assign bus.ack0           = r_ack[0];
    assign bus.ack1           = r_ack[1];
    assign bus.done0          = r_done[0];
    assign bus.done1          = r_done[1];
    assign bus.err            = r_err;
    assign bus.res            = r_res;

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Two-port round-robin arbiter and sequencer for the shared 32×32 Booth multiplier. Accepts signed multiply requests from two requesters and owns the multiplier's `op_start`/`op_clear` handshake. Returns each 64-bit product to the requester that issued it, with a completion pulse, and recovers from a multiplier that never finishes. Sits between the ALU-side requesters and the multiplier instance.

## Interface
- `TIMEOUT`, default 64: maximum busy cycles waiting for `m_op_done` before abort.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req0`, `req1` input 1: request; operands must be valid and stable while high.
- `a0`, `b0`, `a1`, `b1` input 32 each: multiplier / multiplicand operands of each requester.
- `ack0`, `ack1` output 1: one-cycle pulse; request accepted and operands captured.
- `done0`, `done1` output 1: one-cycle pulse; `res` is valid for that requester.
- `res` output 64: product register; holds its value until the next completion.
- `err` output 1: one-cycle pulse coincident with `doneN` on timeout abort.
- `m_multiplier`, `m_multiplicand` output 32: operands driven to the multiplier.
- `m_op_start` output 1: start, held high for the whole operation.
- `m_op_clear` output 1: clear strobe to the multiplier.
- `m_op_done` input 1: multiplier finished.
- `m_result` input 64: multiplier product.

## Operation
- FSM states: IDLE, RUN, CLEAR.
- **IDLE**
  - If any `reqN` is high, select a winner with the round-robin rule.
  - Capture the winner's operands into `m_multiplier`/`m_multiplicand` and record `owner`.
  - Go to RUN.
- **Round robin**
  - A lone request wins.
  - When both requests are high, the winner is the port not granted last (`last_gnt`).
  - `last_gnt` updates on every grant and resets to 1, so port 0 wins the first tie.
- **RUN**
  - `ackN` pulses on the first RUN cycle only.
  - `m_op_start` = 1 throughout RUN.
  - An 8-bit busy counter clears on RUN entry and increments each RUN cycle.
  - If `m_op_done` = 1: capture `m_result` into `res` and go to CLEAR.
  - Else if the counter reaches `TIMEOUT`-1: set `res` = 0, set the abort flag, and go to CLEAR.
- **CLEAR** (one cycle)
  - `m_op_start` = 0 and `m_op_clear` = 1.
  - `done[owner]` = 1; `err` = abort flag.
  - Go to IDLE.
- Requests arriving while the FSM is in RUN or CLEAR are not lost. They wait, and are evaluated in IDLE.
- A requester must drop `reqN` after `ackN`. If `reqN` is still high in IDLE, it is treated as a new request.
- Operands are registered, so the requester may change `aN`/`bN` after `ackN`.
- Arithmetic is a pass-through. `res` is exactly `m_result` (signed 64-bit); the block does no sign handling.
- **Reset**, whether idle or mid-operation:
  - Next state is IDLE and `last_gnt` = 1.
  - `res`, the operand registers, `ackN`, `doneN` and `err` are 0.
  - `m_op_start` = 0.
  - `m_op_clear` = 1 while `reset` is high, which purges any in-flight multiply.
  - No `doneN` is issued for an aborted operation.

## Timing
- Request sampled in IDLE at edge T: `ackN` and `m_op_start` are high during cycle T+1.
- `m_op_done` sampled high at edge D: during cycle D+1, `doneN`, `m_op_clear` and the valid `res` are present; FSM is IDLE at D+2.
- Minimum turnaround, IDLE to IDLE, is 3 + multiplier latency cycles.
- A back-to-back request can be sampled at D+2, giving the next `ack` at D+3.
- Timeout: with no `m_op_done`, `doneN` and `err` are asserted in cycle T+1+`TIMEOUT`.
- If `m_op_done` and the timeout condition occur in the same cycle, `m_op_done` wins: `err` = 0 and the real product is returned.
- All outputs are registered, except `m_op_clear`, which is combinational on `reset` OR state==CLEAR.

## Structure
- Package `mul_arb_pkg` holds:
  - the state enum (IDLE, RUN, CLEAR);
  - `OPW` = 32, `RESW` = 64, `CNTW` = 8.
- Sub-module `rr_arb2`:
  - inputs: `req[1:0]`, `last_gnt`;
  - outputs: `gnt[1:0]` (one-hot or zero) and `gnt_id`.
- The FSM, counter and registers live in `mul_arbiter`.

## Test plan
- **Single request:** `req0`, `a0` = 7, `b0` = -3, multiplier model with 34-cycle latency. Expect `ack0` one cycle after `req0`, `done0` with `res` = 0xFFFF_FFFF_FFFF_FFEB, `m_op_clear` pulse, `err` = 0.
- **Tie after reset:** `req0` and `req1` high in the same cycle. Expect port 0 served first (`res` = `a0`·`b0`), then port 1 (`res` = `a1`·`b1`), with `done0` before `done1` and no `ack` overlap.
- **Continuous contention:** both requests held high for 4 operations. Expect grant order 0,1,0,1.
- **Timeout:** model never raises `m_op_done`, `TIMEOUT` = 64. Expect `done0` and `err` in cycle ack+64, `res` = 0, then return to IDLE and correct service of the next request.
- **Reset mid-RUN:** `reset` pulsed 10 cycles after `ack1`. Expect no `done1`, `m_op_clear` high during reset, outputs 0; afterwards the first tie goes to port 0.
- **Simultaneous done/timeout:** `m_op_done` arrives exactly on the last busy cycle. Expect `err` = 0 and the true product in `res`.
